// File: rtl/scpu_pkg.sv
// SCPU issue control shared definitions: opcodes, func codes,
// instruction field layout and the register-use decode helper.
package scpu_pkg;

   localparam int INSTR_W = 19;
   localparam int NREGS   = 16;

   localparam int OP_HI = 18;
   localparam int OP_LO = 16;
   localparam int RS_HI = 15;
   localparam int RS_LO = 12;
   localparam int RT_HI = 11;
   localparam int RT_LO = 8;
   localparam int RD_HI = 7;
   localparam int RD_LO = 4;
   localparam int RL_HI = 3;
   localparam int RL_LO = 0;

   typedef logic [INSTR_W-1:0] instr_t;
   typedef logic [2:0]         op_t;
   typedef logic [3:0]         reg_t;

   localparam op_t OP_RTYPE = 3'b000;
   localparam op_t OP_MULT  = 3'b001;
   localparam op_t OP_BEQ   = 3'b010;
   localparam op_t OP_ADDI  = 3'b011;
   localparam op_t OP_SUBI  = 3'b100;
   localparam op_t OP_STORE = 3'b101;
   localparam op_t OP_LOAD  = 3'b110;
   localparam op_t OP_SLT   = 3'b111;

   localparam reg_t FN_AND = 4'd0;
   localparam reg_t FN_OR  = 4'd1;
   localparam reg_t FN_XOR = 4'd2;
   localparam reg_t FN_ADD = 4'd3;
   localparam reg_t FN_SUB = 4'd4;

   typedef struct packed {
      logic [NREGS-1:0] src;
      logic [NREGS-1:0] dst;
   } regs_t;

   function automatic logic [NREGS-1:0] reg_bit(input reg_t r);
      return NREGS'(1) << r;
   endfunction

   function automatic regs_t decode_regs(input instr_t i);
      op_t   op;
      reg_t  rs;
      reg_t  rt;
      reg_t  rd;
      reg_t  rl;
      regs_t m;
      op = i[OP_HI:OP_LO];
      rs = i[RS_HI:RS_LO];
      rt = i[RT_HI:RT_LO];
      rd = i[RD_HI:RD_LO];
      rl = i[RL_HI:RL_LO];
      m  = '0;
      case (op)
         OP_RTYPE: begin
            m.src = reg_bit(rs) | reg_bit(rt);
            // funcs above SUB are compare/no-write forms
            if (rl <= FN_SUB) m.dst = reg_bit(rd);
         end
         OP_MULT, OP_BEQ, OP_SLT: begin
            m.src = reg_bit(rs) | reg_bit(rt);
            m.dst = reg_bit(rd) | reg_bit(rl);
         end
         OP_ADDI, OP_SUBI, OP_LOAD: begin
            m.src = reg_bit(rs);
            m.dst = reg_bit(rt);
         end
         OP_STORE: begin
            m.src = reg_bit(rs) | reg_bit(rt);
         end
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/scpu_instr_fifo.sv
// Synchronous instruction FIFO with a registered full flag
// and a look-ahead empty flag for the idle register.
module scpu_instr_fifo
   import scpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  instr_t push_data,
   input  logic   pop,
   output instr_t head,
   output logic   full,
   output logic   empty,
   output logic   empty_nxt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_n;
   logic          do_push;
   logic          do_pop;
   instr_t        mem [DEPTH];

   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign empty     = (count == '0);
   assign empty_nxt = (count_n == '0);
   assign head      = mem[rd_ptr];

   always_comb begin
      count_n = count;
      unique case ({do_push, do_pop})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else begin
         count <= count_n;
         // full looks at the next count, so a same-cycle pop never reopens it early
         full  <= (count_n == FULL_CNT);
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/scpu_issue_ctrl.sv
// In-order RAW-checking issue controller for the SCPU datapath.
// Optional hazard-stall counter: define SCPU_ISSUE_STATS_EN.
module scpu_issue_ctrl
   import scpu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WB_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        host_valid,
   input  logic [18:0] host_instr,
   output logic        host_ready,
   input  logic        cpu_busy,
   output logic        cpu_in_valid,
   output logic [18:0] cpu_instruction,
   output logic        idle,
   output logic [15:0] stall_cycles
);

   localparam int CW = $clog2(WB_LAT + 1);
   localparam logic [CW-1:0] LOAD_V = CW'(WB_LAT - 1);

   logic             full;
   logic             empty;
   logic             empty_nxt;
   logic             push;
   logic             issue;
   logic             hazard;
   logic             cnt_clr_n;
   instr_t           head;
   regs_t            regs;
   logic [NREGS-1:0] busy_m;
   logic [CW-1:0]    cnt   [NREGS];
   logic [CW-1:0]    cnt_n [NREGS];

   assign host_ready = !full;
   assign push       = host_valid && !full;

   scpu_instr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (host_instr),
      .pop       (issue),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .empty_nxt (empty_nxt)
   );

   assign regs = decode_regs(head);

   always_comb begin
      busy_m = '0;
      for (int r = 0; r < NREGS; r++) busy_m[r] = (cnt[r] != '0);
   end

   assign hazard = |(regs.src & busy_m);
   assign issue  = !empty && !cpu_busy && !hazard;

   // a fresh load wins over the decrement of an older writer
   always_comb begin
      cnt_clr_n = 1'b1;
      for (int r = 0; r < NREGS; r++) begin
         cnt_n[r] = cnt[r];
         if (issue && regs.dst[r]) cnt_n[r] = LOAD_V;
         else if (busy_m[r]) cnt_n[r] = cnt[r] - 1'b1;
         if (cnt_n[r] != '0) cnt_clr_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_in_valid    <= 1'b0;
         cpu_instruction <= '0;
         idle            <= 1'b1;
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      end else begin
         cpu_in_valid <= issue;
         if (issue) cpu_instruction <= head;
         idle <= empty_nxt && !issue && cnt_clr_n;
         for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_n[r];
      end
   end

`ifdef SCPU_ISSUE_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (!empty && !cpu_busy && hazard && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_scpu_issue_ctrl.sv
// Self-checking bench for scpu_issue_ctrl: pair table plus
// hand sequences, with an in-order issue scoreboard.
module tb_scpu_issue_ctrl;
   import scpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int WB    = 4;
`ifdef SCPU_ISSUE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        host_valid = 1'b0;
   logic [18:0] host_instr = '0;
   logic        host_ready;
   logic        cpu_busy = 1'b0;
   logic        cpu_in_valid;
   logic [18:0] cpu_instruction;
   logic        idle;
   logic [15:0] stall_cycles;

   scpu_issue_ctrl #(
      .DEPTH  (DEPTH),
      .WB_LAT (WB)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .host_valid      (host_valid),
      .host_instr      (host_instr),
      .host_ready      (host_ready),
      .cpu_busy        (cpu_busy),
      .cpu_in_valid    (cpu_in_valid),
      .cpu_instruction (cpu_instruction),
      .idle            (idle),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int     pass_n = 0;
   int     total_n = 0;
   instr_t exp_q[$];
   int     iss_q[$];
   int     last_acc;

   typedef struct {
      instr_t a;
      instr_t b;
      int     gap;
   } vec_t;
   vec_t tv[15];

   task automatic chk(input string nm, input longint got, input longint exp);
      total_n++;
      if (got == exp) pass_n++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   function automatic instr_t mk(input logic [2:0] op, input int rs,
                                 input int rt, input int rd, input int rl);
      return {op, 4'(rs), 4'(rt), 4'(rd), 4'(rl)};
   endfunction

   always @(negedge clk) begin
      if (rst_n && cpu_in_valid) begin
         if (exp_q.size() == 0) begin
            total_n++;
            $display("FAIL unexpected_issue: got instr %h expected none",
                     cpu_instruction);
         end else begin
            chk("issue_instr", cpu_instruction, exp_q.pop_front());
         end
         iss_q.push_back(cyc);
      end
   end

   task automatic push(input instr_t i);
      bit acc;
      host_instr = i;
      host_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         acc = host_ready;
         last_acc = cyc;
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(i);
            @(negedge clk);
            host_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      total_n++;
      $display("FAIL push_timeout: got no accept expected accept");
      host_valid = 1'b0;
   endtask

   task automatic wait_iss(input int n, input string nm);
      for (int k = 0; k < 100; k++) begin
         if (iss_q.size() >= n) return;
         @(negedge clk);
         #1;
      end
      total_n++;
      $display("FAIL %s: got %0d issues expected %0d", nm, iss_q.size(), n);
   endtask

   task automatic wait_idle(input string nm);
      for (int k = 0; k < 100; k++) begin
         if (idle) return;
         @(negedge clk);
         #1;
      end
      total_n++;
      $display("FAIL %s: got idle 0 expected 1", nm);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int a0;
      int lst;

      tv[0]  = '{mk(OP_RTYPE,1,2,3,FN_ADD), mk(OP_RTYPE,4,5,6,FN_XOR), 1};
      tv[1]  = '{mk(OP_ADDI,0,1,0,3),       mk(OP_RTYPE,1,1,2,FN_ADD), WB};
      tv[2]  = '{mk(OP_LOAD,0,2,1,0),       mk(OP_STORE,0,2,1,1),      WB};
      tv[3]  = '{mk(OP_STORE,0,2,1,1),      mk(OP_LOAD,0,3,1,0),       1};
      tv[4]  = '{mk(OP_RTYPE,1,2,7,5),      mk(OP_RTYPE,7,1,8,FN_ADD), 1};
      tv[5]  = '{mk(OP_MULT,1,2,4,5),       mk(OP_SUBI,5,6,0,1),       WB};
      tv[6]  = '{mk(OP_MULT,1,2,9,9),       mk(OP_RTYPE,3,9,10,FN_ADD),WB};
      tv[7]  = '{mk(OP_SLT,1,2,10,11),      mk(OP_ADDI,11,12,0,1),     WB};
      tv[8]  = '{mk(OP_BEQ,1,2,13,14),      mk(OP_RTYPE,13,0,1,FN_SUB),WB};
      tv[9]  = '{mk(OP_ADDI,1,3,0,1),       mk(OP_STORE,0,3,0,0),      WB};
      tv[10] = '{mk(OP_ADDI,12,12,0,1),     mk(OP_ADDI,12,12,0,1),     WB};
      tv[11] = '{mk(OP_LOAD,0,15,0,0),      mk(OP_RTYPE,14,15,1,FN_SUB),WB};
      tv[12] = '{mk(OP_ADDI,0,5,0,0),       mk(OP_STORE,4,6,0,0),      1};
      tv[13] = '{mk(OP_RTYPE,1,2,0,FN_AND), mk(OP_ADDI,0,1,0,0),       WB};
      tv[14] = '{mk(OP_SUBI,2,13,0,1),      mk(OP_RTYPE,1,2,3,FN_OR),  1};

      repeat (3) @(negedge clk);
      chk("rst_host_ready", host_ready, 1);
      chk("rst_in_valid", cpu_in_valid, 0);
      chk("rst_instr", cpu_instruction, 0);
      chk("rst_idle", idle, 1);
      chk("rst_stall", stall_cycles, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (tv[i]) begin
         wait_idle("idle_before_pair");
         iss_q.delete();
         s0 = stall_cycles;
         push(tv[i].a);
         push(tv[i].b);
         wait_iss(2, "pair_issue");
         if (iss_q.size() >= 2)
            chk($sformatf("pair%0d_gap", i), iss_q[1] - iss_q[0], tv[i].gap);
         wait_idle("idle_after_pair");
         chk($sformatf("pair%0d_stall", i), stall_cycles - s0,
             STATS ? tv[i].gap - 1 : 0);
      end

      // independent stream, back-to-back
      wait_idle("idle_before_stream");
      iss_q.delete();
      s0 = stall_cycles;
      push(mk(OP_RTYPE,1,2,3,FN_ADD));
      a0 = last_acc;
      push(mk(OP_RTYPE,4,5,6,FN_XOR));
      push(mk(OP_ADDI,7,8,0,5));
      wait_iss(3, "stream_issue");
      if (iss_q.size() >= 3) begin
         chk("stream_latency", iss_q[0] - a0, 2);
         chk("stream_gap1", iss_q[1] - iss_q[0], 1);
         chk("stream_gap2", iss_q[2] - iss_q[1], 1);
      end
      wait_idle("idle_after_stream");
      chk("stream_stall", stall_cycles - s0, 0);

      // MULT dual dst with an independent AND slipping behind it
      iss_q.delete();
      s0 = stall_cycles;
      push(mk(OP_MULT,1,2,4,5));
      push(mk(OP_RTYPE,7,8,9,FN_AND));
      push(mk(OP_SUBI,5,6,0,1));
      wait_iss(3, "mult_issue");
      if (iss_q.size() >= 3) begin
         chk("mult_and_gap", iss_q[1] - iss_q[0], 1);
         chk("mult_subi_gap", iss_q[2] - iss_q[0], WB);
      end
      wait_idle("idle_after_mult");
      chk("mult_stall", stall_cycles - s0, STATS ? 2 : 0);

      // backpressure with the CPU busy
      iss_q.delete();
      cpu_busy = 1'b1;
      push(mk(OP_RTYPE,1,2,3,FN_ADD));
      push(mk(OP_RTYPE,4,5,6,FN_XOR));
      push(mk(OP_RTYPE,7,8,9,FN_OR));
      push(mk(OP_SUBI,11,10,0,1));
      chk("bp_ready_low", host_ready, 0);
      fork
         push(mk(OP_ADDI,13,12,0,2));
      join_none
      repeat (3) @(negedge clk);
      #1;
      chk("bp_ready_held", host_ready, 0);
      chk("bp_accepted", exp_q.size(), 4);
      chk("bp_no_issue", iss_q.size(), 0);
      cpu_busy = 1'b0;
      wait_iss(5, "bp_drain");
      if (iss_q.size() >= 5) begin
         lst = iss_q[4];
         while (cyc < lst + WB - 2) @(negedge clk);
         chk("bp_idle_early", idle, 0);
         @(negedge clk);
         chk("bp_idle_after", idle, 1);
      end
      chk("bp_queue_empty", exp_q.size(), 0);

      // reset with entries queued and counters running
      wait_idle("idle_before_reset");
      push(mk(OP_ADDI,0,1,0,3));
      push(mk(OP_RTYPE,1,1,2,FN_ADD));
      push(mk(OP_RTYPE,4,5,6,FN_XOR));
      push(mk(OP_RTYPE,7,8,3,FN_ADD));
      chk("pre_reset_busy", idle, 0);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_valid", cpu_in_valid, 0);
      chk("mid_rst_instr", cpu_instruction, 0);
      chk("mid_rst_ready", host_ready, 1);
      chk("mid_rst_idle", idle, 1);
      chk("mid_rst_stall", stall_cycles, 0);
      repeat (2) @(negedge clk);
      iss_q.delete();
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("post_rst_no_issue", iss_q.size(), 0);
      chk("post_rst_idle", idle, 1);
      chk("post_rst_ready", host_ready, 1);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
